// File: rtl/oram_path_fetch_pkg.sv
// oram_path_fetch_pkg: shared sizes, packed tuple/bucket layout and FSM states for the path fetch
package oram_path_fetch_pkg;
  localparam int A = 8;
  localparam int D = 6;
  localparam int K = 3;
  localparam int P = D - 1;
  localparam int TUPLE_W = P + 1 + D + 8 * A + 1 + 1;
  localparam int BUCKET_W = K * TUPLE_W;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  typedef struct packed {
    logic [P-1:0] pos;
    logic pos_valid;
    logic [D-1:0] number;
    logic [8*A-1:0] val;
    logic val_valid;
    logic empty_n;
  } memory_tuple_p;
  typedef memory_tuple_p [K-1:0] memory_bucket_p;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_RD,
    S_WB,
    S_RESP
  } state_e;
  function automatic logic tuple_match(input memory_tuple_p t, input logic [P-1:0] leaf,
                                       input logic [D-1:0] blk);
    return t.empty_n && t.pos_valid && (t.pos == leaf) && (t.number == blk);
  endfunction
endpackage

// File: rtl/oram_lfsr.sv
// oram_lfsr: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) exposing its low bits
module oram_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [OUT_W-1:0] lfsr_out
);
  logic [15:0] state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= SEED;
    else state <= {state[0] ^ state[2] ^ state[3] ^ state[5], state[15:1]};
  assign lfsr_out = state[OUT_W-1:0];
endmodule

// File: rtl/oram_path_fetch.sv
// oram_path_fetch: remaps a block's leaf and reads/invalidates/writes back every bucket on its path
module oram_path_fetch
  import oram_path_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [D-1:0]        req_block,
  output logic                mem_rd_en,
  output logic                mem_wr_en,
  output logic [D-1:0]        mem_addr,
  input  logic [BUCKET_W-1:0] mem_rd_data,
  output logic [BUCKET_W-1:0] mem_wr_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_hit,
  output logic [8*A-1:0]      resp_val,
  output logic [D-1:0]        resp_block,
  output logic [P-1:0]        resp_new_pos
);
  localparam logic [2:0] LAST = 3'(D - 1);
  state_e state, state_nx;
  logic [P-1:0] lfsr_lo;
  logic [D-1:0] posmap [2**D];
  logic [D-1:0] pm_entry;
  logic [D-1:0] blk;
  logic [D-1:0] node;
  logic [P-1:0] leaf;
  logic [2:0] lvl;
  logic dummy;
  memory_bucket_p bkt_in, bkt_out;
  logic any_match;
  logic [8*A-1:0] first_val;
  oram_lfsr #(.SEED(LFSR_SEED), .OUT_W(P)) u_lfsr (
    .clk(clk),
    .rst_n(rst_n),
    .lfsr_out(lfsr_lo)
  );
  assign pm_entry = posmap[blk];
  assign bkt_in = mem_rd_data;
  // Descending scan so the lowest-index match wins within a bucket; dummy walks never match
  always_comb begin
    bkt_out = bkt_in;
    any_match = 1'b0;
    first_val = '0;
    for (int k = K - 1; k >= 0; k--)
      if (!dummy && tuple_match(bkt_in[k], leaf, blk)) begin
        bkt_out[k].empty_n = 1'b0;
        any_match = 1'b1;
        first_val = bkt_in[k].val;
      end
  end
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = req_valid ? S_LOOKUP : S_IDLE;
      S_LOOKUP: state_nx = S_RD;
      S_RD:     state_nx = S_WB;
      S_WB:     state_nx = (lvl == LAST) ? S_RESP : S_RD;
      S_RESP:   state_nx = resp_ready ? S_IDLE : S_RESP;
      default:  state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 2**D; i++) posmap[i] <= '0;
      blk <= '0;
      leaf <= '0;
      node <= '0;
      lvl <= '0;
      dummy <= 1'b0;
      resp_hit <= 1'b0;
      resp_val <= '0;
      resp_new_pos <= '0;
    end else begin
      if (state == S_IDLE && req_valid) blk <= req_block;
      if (state == S_LOOKUP) begin
        leaf <= pm_entry[D-1] ? pm_entry[P-1:0] : lfsr_lo;
        dummy <= !pm_entry[D-1];
        posmap[blk] <= {1'b1, lfsr_lo};
        resp_new_pos <= lfsr_lo;
        resp_hit <= 1'b0;
        resp_val <= '0;
        node <= D'(1);
        lvl <= '0;
      end
      if (state == S_WB) begin
        if (any_match && !resp_hit) begin
          resp_hit <= 1'b1;
          resp_val <= first_val;
        end
        if (lvl != LAST) begin
          lvl <= lvl + 1'b1;
          node <= {node[D-2:0], leaf[lvl]};
        end
      end
    end
  assign req_ready = state == S_IDLE;
  assign mem_rd_en = state == S_RD;
  assign mem_wr_en = state == S_WB;
  assign mem_addr = (mem_rd_en || mem_wr_en) ? node - 1'b1 : '0;
  assign mem_wr_data = mem_wr_en ? bkt_out : '0;
  assign resp_valid = state == S_RESP;
  assign resp_block = blk;
endmodule

// File: doc/oram_path_fetch.md
# oram_path_fetch

Synthesizable access front end of the ORAM controller. It accepts a block-number request, looks up and remaps the block's leaf in an internal position map, and walks the root-to-leaf path in the external bucket memory. Every bucket on the path is read and written back, with any matching tuple invalidated. It returns the block value, hit flag and new leaf to the downstream put-back/eviction stage.

## Interface
- `A`, 8: bytes per block value.
- `D`, 6: tree depth in levels including root; leaf pos is `D-1` bits; block number is `D` bits.
- `K`, 3: tuples per bucket.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block idle, request accepted when both high.
- `req_block`  in  D  block number to fetch.
- `mem_rd_en`  out  1  bucket read strobe.
- `mem_wr_en`  out  1  bucket write strobe.
- `mem_addr`  out  D  bucket index (node number − 1).
- `mem_rd_data`  in  K*TUPLE_W  bucket, valid exactly one cycle after `mem_rd_en`.
- `mem_wr_data`  out  K*TUPLE_W  modified bucket.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts.
- `resp_hit`  out  1  block found on path.
- `resp_val`  out  8*A  block value; zero on miss.
- `resp_block`  out  D  echoed block number.
- `resp_new_pos`  out  D-1  leaf newly assigned in the position map.

## Operation
- FSM: IDLE → LOOKUP → (RD ↔ WB) × D → RESP → IDLE.
- IDLE: `req_ready`=1. On handshake, latch `req_block`.
- LOOKUP: read `posmap[req_block]`.
  - If the entry is valid, the walk leaf is the stored pos.
  - If the entry is invalid, the walk leaf is the current LFSR low `D-1` bits. This is a dummy walk and always misses.
  - In the same cycle, write `posmap[req_block]` = {valid=1, pos=LFSR low bits}. Latch this value as `resp_new_pos`.
- Walk: node starts at 1 (root). At level L (1..D-1), node = 2·node + pos[L−1], LSB first. `mem_addr` = node − 1.
- RD: `mem_rd_en`=1 with the current node address.
- WB: `mem_rd_data` arrives. Each tuple k matches when tuple.empty_n & b_pos.empty_n & b_pos.pos==walk leaf & b_number==req_block.
  - Every matching tuple has `empty_n` cleared.
  - The shallowest match supplies `resp_val` and sets `resp_hit`.
  - `mem_wr_en`=1 and `mem_wr_data` = modified bucket at the same address. This write happens even with no match, so the access pattern stays oblivious.
- The walk always covers all D levels; a hit never terminates it early.
- RESP: `resp_valid`=1. Outputs stay stable until `resp_ready`, then the FSM returns to IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1. It advances every cycle regardless of state.

## Timing
- Reset (async assert, sync deassert):
  - FSM in IDLE; `req_ready`=1.
  - All other outputs 0.
  - All position-map entries invalid; LFSR = seed.
- Reset mid-walk abandons the access. A partially written path is acceptable; no response is produced.
- Handshake at cycle 0; LOOKUP at cycle 1.
- RD at cycles 2, 4, …, 2D; WB at cycles 3, 5, …, 2D+1.
- `resp_valid` rises at cycle 2D+2 (14 for D=6). This latency is fixed for hit, miss and dummy walks.
- Back-to-back throughput: one access per 2D+3 cycles when `resp_ready` is held high.
- `req_ready`=0 from cycle 1 until the cycle after the response handshake. `req_valid` during that window is ignored (not queued).
- `mem_rd_en` and `mem_wr_en` are never high in the same cycle.

## Structure
- Add to `oramPkg` packed mirrors of the existing tuple types:
  - `memory_tuple_p`: pos, pos valid, number, val, val valid, empty_n; `TUPLE_W` = (D−1)+1+D+8A+1+1 = 78.
  - `memory_bucket_p`: K×tuple, 234 bits.
  - FSM state enum.
- Sub-module `oram_lfsr`: 16-bit LFSR with seed parameter and `lfsr_out`.
- The position map is a register array of 2^D × D bits inside this block.

## Test plan
- After reset, `req_block`=5 with the position map empty → dummy walk of 6 reads and 6 writes; resp at cycle 14 with hit=0, val=0; posmap[5] valid.
- Preload tuple {block 5, pos = posmap[5], val 64'h0123456789ABCDEF} at depth 3 on that path; request 5 → hit=1, val matches; that tuple is written back with empty_n=0; `resp_new_pos` differs from the old pos (given LFSR state).
- Same block present at the root and at a leaf with matching pos → value comes from the root; both tuples are cleared.
- Tuple with correct block number but wrong pos, on the path → hit=0; tuple is unchanged in the write-back.
- Hold `resp_ready`=0 for 5 cycles → outputs stable, `req_ready`=0, a second `req_valid` is ignored; after release, a new request is accepted in IDLE.
- Assert `rst_n` at cycle 7 of a walk → all outputs 0 immediately; position map cleared; next request behaves as a first access.
